// File: rtl/spi_receiver_if.sv
// spi_receiver_if: core-side receive FIFO port of the SPI receiver.
// master = core (pops, clears overflow); slave = receiver.
interface spi_receiver_if #(
  parameter int PTR_W = 5
);
  logic             ren;
  logic             clr_overflow;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             full;
  logic             overflow;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;

  modport master (
    output ren, clr_overflow,
    input  r_data, r_valid, full,
    input  overflow, rptr, wptr
  );

  modport slave (
    input  ren, clr_overflow,
    output r_data, r_valid, full,
    output overflow, rptr, wptr
  );
endinterface

// File: rtl/spi_receiver.sv
// spi_receiver: mode-0 MISO deserialiser feeding a FWFT receive FIFO.
// Ports: clk, rst (sync, active-low), SCLK, MISO, frame_clr,
//   rx (slave): ren, clr_overflow, r_data, r_valid, full,
//   overflow, rptr, wptr.
// Option: define SPI_RX_LSB_FIRST_EN for LSB-first reception.
module spi_receiver #(
  parameter int MISO_BUFFER_DEPTH = 16,
  parameter int PTR_W = $clog2(MISO_BUFFER_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          SCLK,
  input  logic          MISO,
  input  logic          frame_clr,
  spi_receiver_if.slave rx
);
  localparam int AW = PTR_W - 1;

  logic             sclk_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] wptr_q;
  logic             ovf_q;
  logic [7:0]       mem [MISO_BUFFER_DEPTH];

  logic       rise;
  logic       push;
  logic       pop;
  logic       empty;
  logic       full_w;
  logic       wr_en;
  logic [7:0] shift_nx;

  assign rise = SCLK & ~sclk_q;

`ifdef SPI_RX_LSB_FIRST_EN
  assign shift_nx = {MISO, shift_q[7:1]};
`else
  assign shift_nx = {shift_q[6:0], MISO};
`endif

  // frame_clr beats a coincident rise, so it also blocks the push
  assign push   = rise & ~frame_clr & (bit_cnt_q == 3'd7);
  assign empty  = (rptr_q == wptr_q);
  assign full_w = (rptr_q[AW-1:0] == wptr_q[AW-1:0]) &
                  (rptr_q[AW] != wptr_q[AW]);
  assign pop    = rx.ren & ~empty;
  // a pop frees the slot the push lands in when full
  assign wr_en  = push & (~full_w | pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_q    <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sclk_q <= SCLK;
      if (frame_clr) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (rise) begin
        shift_q   <= shift_nx;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      if (wr_en)
        wptr_q <= wptr_q + 1'b1;
      if (push & full_w & ~pop)
        ovf_q <= 1'b1;
      else if (rx.clr_overflow)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en)
      mem[wptr_q[AW-1:0]] <= shift_nx;
  end

  // gated so r_data reads zero whenever nothing is queued
  assign rx.r_data   = empty ? 8'h00 : mem[rptr_q[AW-1:0]];
  assign rx.r_valid  = ~empty;
  assign rx.full     = full_w;
  assign rx.overflow = ovf_q;
  assign rx.rptr     = rptr_q;
  assign rx.wptr     = wptr_q;
endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: scoreboard bench for spi_receiver.
// Expected bytes queue on send, compare on pop.
module tb_spi_receiver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic SCLK = 1'b0;
  logic MISO = 1'b0;
  logic frame_clr = 1'b0;

  spi_receiver_if #(.PTR_W(5)) rx ();

  spi_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .SCLK      (SCLK),
    .MISO      (MISO),
    .frame_clr (frame_clr),
    .rx        (rx.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];
  logic [4:0] e_wptr = '0;
  logic [4:0] e_rptr = '0;
  logic       e_ovf  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".valid"}, rx.r_valid, sb.size() != 0);
    chk({tag, ".full"}, rx.full, sb.size() == 16);
    chk({tag, ".ovf"}, rx.overflow, e_ovf);
    chk({tag, ".wptr"}, rx.wptr, e_wptr);
    chk({tag, ".rptr"}, rx.rptr, e_rptr);
  endtask

  // one SCLK rise; ren/clr/frame_clr are held for the rise cycle
  task automatic rise(input logic b, input logic fc,
                      input logic r, input logic co);
    MISO = b;
    SCLK = 1'b1;
    frame_clr = fc;
    rx.ren = r;
    rx.clr_overflow = co;
    if (r && sb.size() != 0) begin
      chk("pop_at_rise", rx.r_data, sb[0]);
      void'(sb.pop_front());
      e_rptr++;
    end
    tick();
    SCLK = 1'b0;
    frame_clr = 1'b0;
    rx.ren = 1'b0;
    rx.clr_overflow = 1'b0;
    tick();
  endtask

  function automatic logic bit_of(input logic [7:0] b, input int i);
`ifdef SPI_RX_LSB_FIRST_EN
    return b[i];
`else
    return b[7-i];
`endif
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (sb.size() < 16) begin
      sb.push_back(b);
      e_wptr++;
    end else begin
      e_ovf = 1'b1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b,
                           input logic r_last,
                           input logic co);
    for (int i = 0; i < 8; i++)
      rise(bit_of(b, i), 1'b0, r_last && i == 7, co);
    model_push(b);
  endtask

  task automatic pop();
    chk("pop.valid", rx.r_valid, 1'b1);
    chk("pop.data", rx.r_data, sb[0]);
    void'(sb.pop_front());
    e_rptr++;
    rx.ren = 1'b1;
    tick();
    rx.ren = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    sb.delete();
    e_wptr = '0;
    e_rptr = '0;
    e_ovf  = 1'b0;
    chk_state("rst");
    chk("rst.data", rx.r_data, 8'h00);
    rst = 1'b1;
    tick();
  endtask

  logic [7:0] pat;
  logic [7:0] raw;

  initial begin
    rx.ren = 1'b0;
    rx.clr_overflow = 1'b0;
    tick();
    do_reset();

    // A5 with explicit one-cycle latency check
    pat = 8'hA5;
    for (int i = 0; i < 7; i++)
      rise(bit_of(pat, i), 1'b0, 1'b0, 1'b0);
    chk("a5.pre_valid", rx.r_valid, 1'b0);
    MISO = bit_of(pat, 7);
    SCLK = 1'b1;
    tick();
    chk("a5.lat_valid", rx.r_valid, 1'b1);
    chk("a5.lat_data", rx.r_data, 8'hA5);
    chk("a5.lat_wptr", rx.wptr, 5'd1);
    SCLK = 1'b0;
    tick();
    model_push(8'hA5);
    pop();
    chk_state("a5.after");

    // ren on empty FIFO is ignored
    rx.ren = 1'b1;
    tick();
    rx.ren = 1'b0;
    chk_state("empty_ren");

    // fill to full, overflow, set-beats-clear
    do_reset();
    for (int i = 0; i < 16; i++)
      send_byte(i[7:0], 1'b0, 1'b0);
    chk_state("fill16");
    send_byte(8'hFF, 1'b0, 1'b0);
    chk_state("ovf_ff");
    send_byte(8'hEE, 1'b0, 1'b1);
    chk_state("ovf_setwins");
    rx.clr_overflow = 1'b1;
    tick();
    rx.clr_overflow = 1'b0;
    e_ovf = 1'b0;
    chk_state("ovf_clr");

    // push and pop together while full
    send_byte(8'h3C, 1'b1, 1'b0);
    chk_state("full_pushpop");
    while (sb.size() != 0)
      pop();
    chk_state("drained");

    // frame_clr mid-byte, including one coincident with a rise
    for (int i = 0; i < 5; i++)
      rise(1'b1, 1'b0, 1'b0, 1'b0);
    rise(1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h81, 1'b0, 1'b0);
    chk_state("fclr");
    pop();
    chk_state("fclr.one");

    // reset mid-byte with bytes queued
    for (int i = 0; i < 3; i++)
      send_byte(8'h10 + i[7:0], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      rise(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_byte(8'h5A, 1'b0, 1'b0);
    chk_state("post_rst");
    pop();

    // raw bit pattern 1,1,0,0,0,0,0,0
    raw = 8'b1100_0000;
    for (int i = 0; i < 8; i++)
      rise(raw[7-i], 1'b0, 1'b0, 1'b0);
`ifdef SPI_RX_LSB_FIRST_EN
    model_push(8'h03);
`else
    model_push(8'hC0);
`endif
    pop();

    // pointer wrap past 2*DEPTH
    for (int i = 0; i < 40; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      pop();
    end
    chk_state("wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_receiver.md
Name: spi_receiver

Overview:
- MISO deserialiser, the receive-side companion of the SPI transmit stage; consumes the SCLK that stage generates plus the external MISO line.
- Samples MISO on SCLK rising edges (mode 0, MSB first) and assembles bytes.
- Completed bytes go into an internal receive FIFO, which the core drains via a first-word-fall-through read port.
- Sticky overflow flag records bytes dropped while the FIFO is full.

Parameters:
MISO_BUFFER_DEPTH, 16, receive FIFO depth in bytes; power of two, >= 2
PTR_W, $clog2(MISO_BUFFER_DEPTH)+1, FIFO pointer width including wrap bit (5 at default)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
SCLK  input  1  SPI serial clock from transmit stage, synchronous to clk
MISO  input  1  serial data in, synchronous to clk
frame_clr  input  1  discard partial byte and realign bit counter
ren  input  1  pop head of receive FIFO
r_data  output  8  head byte of FIFO, valid when r_valid=1
r_valid  output  1  FIFO non-empty
full  output  1  FIFO holds MISO_BUFFER_DEPTH bytes
overflow  output  1  sticky: a completed byte was dropped
clr_overflow  input  1  clear overflow
rptr  output  PTR_W  FIFO read pointer
wptr  output  PTR_W  FIFO write pointer

Behaviour:
- Reset (rst=0 at clk edge) overrides everything:
  - outputs: r_valid=0, full=0, overflow=0, rptr=0, wptr=0, r_data=0.
  - internal state: sclk_q=0, shift register=0, bit count=0.
- Edge detect: sclk_q <= SCLK every cycle; rise = SCLK & ~sclk_q. Only rising edges act.
- On rise:
  - shift <= {shift[6:0], MISO}.
  - bit_cnt <= bit_cnt+1, 3-bit, wraps 7->0.
- Byte complete = rise while bit_cnt==7:
  - assembled byte {shift[6:0], MISO} is pushed the same cycle.
  - visible on r_data with r_valid=1 the next cycle, if FIFO was empty.
  - latency: 1 clk from the 8th SCLK rising edge seen on the port.
- frame_clr=1: bit_cnt<=0, shift<=0. If coincident with a rise, frame_clr wins: no shift, no push. FIFO contents untouched.
- FIFO:
  - circular buffer; pointers PTR_W bits, index = low bits.
  - empty: rptr==wptr. full: low bits equal, MSBs differ.
  - r_data = mem[rptr index], combinational from storage.
  - ren with r_valid=1: rptr increments. ren with r_valid=0: ignored, rptr unchanged.
  - push when not full: mem[wptr]<=byte, wptr increments.
  - push when full, no pop same cycle: byte dropped, wptr unchanged, overflow<=1.
  - push and ren same cycle while full: both occur, full stays 1, no overflow.
  - push and ren same cycle while empty: push only, byte visible next cycle.
- overflow: sticky until clr_overflow=1. A set and a clear in the same cycle resolve to 1 (set wins).
- Pointers wrap naturally through 2*DEPTH.
- Reset mid-byte: partial byte lost. The next rise after reset is treated as bit 0.

Optional Feature:
SPI_RX_LSB_FIRST_EN
- Defined: LSB-first reception; shift <= {MISO, shift[7:1]}; completed byte = {MISO, shift[7:1]}.
- Undefined: MSB-first as above.
- All other timing identical.

Test Plan:
- Reset release, then 8 SCLK rises with MISO = 1,0,1,0,0,1,0,1 -> 1 clk after 8th rise r_valid=1, r_data=8'hA5, wptr=1; ren one cycle -> r_valid=0, rptr=1.
- Stream 16 bytes 8'h00..8'h0F without reading -> full=1, wptr=5'h10, overflow=0; 17th byte 8'hFF -> overflow=1, wptr=5'h10. Drain 16 -> r_data sequence 00..0F, no FF.
- FIFO full, 8th rise of byte 8'h3C coincides with ren -> 8'h00 popped, 3C stored, full=1, overflow=0.
- 5 rises then frame_clr, then 8 rises of 8'h81 -> single byte 8'h81 received.
- rst=0 after 4 rises with 3 bytes queued -> all outputs zero next cycle; following 8 rises of 8'h5A -> r_data=8'h5A.
- With SPI_RX_LSB_FIRST_EN, MISO = 1,0,1,0,0,1,0,1 -> r_data=8'hA5. Pattern 1,1,0,0,0,0,0,0 -> 8'h03.
